sfifo_uart_tx: RTL and testbench
================================

# sfifo_uart_tx

Downstream drain stage for the 16×8 synchronous FIFO. It pops one byte at a time whenever the FIFO reports not-empty and serializes each byte as an asynchronous 8N1 frame on a single output line. The FIFO's read data is registered, which gives this block its fetch/load cadence. Its outputs feed the user-area GPIO pad for a serial link off-chip.

## Interface
- `CLKS_PER_BIT`, default 16: CLK cycles per serial bit; legal range ≥ 2.
- `DATA_W`, default 8: byte width; must match the FIFO data width.
- `CLK`  input  1  — single clock, rising edge.
- `RST`  input  1  — asynchronous, active-high reset.
- `fifo_empty`  input  1  — FIFO empty flag.
- `fifo_data`  input  DATA_W  — FIFO registered read data. Valid the cycle after `fifo_rd`.
- `fifo_rd`  output  1  — FIFO read strobe; one-cycle pulse per byte.
- `tx`  output  1  — serial line; idles high.
- `busy`  output  1  — high whenever state ≠ IDLE.
- `tx_done`  output  1  — one-cycle pulse in the final stop-bit cycle.

## Operation
- All outputs are registered or Moore-decoded from state. No combinational path exists from input to output.
- FSM states and transitions:
  - IDLE → FETCH when `fifo_empty`=0.
  - FETCH → LOAD unconditionally. `fifo_rd`=1 only in FETCH.
  - LOAD → START. `fifo_data` is captured into the shift register on the edge leaving LOAD.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after `DATA_W` bits. With parity compiled in, DATA → PARITY → STOP instead.
  - STOP → IDLE after `CLKS_PER_BIT` cycles.
- Line levels: start bit = 0; data bits LSB first; stop bit = 1.
- Bit counter: 0 … `CLKS_PER_BIT`−1, width `$clog2(CLKS_PER_BIT)`.
- Bit index counter: 0 … `DATA_W`−1.
- Both counters wrap to 0 on each bit/state transition.
- `fifo_empty` is sampled only in IDLE. Changes in any other state are ignored.
- Exactly one pop occurs per frame, so the FIFO can never be over-read.
- Reset values, also forced asynchronously mid-frame: state=IDLE, `tx`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, counters=0, shift register=0.
  - A byte already popped when reset hits is discarded.
  - The partial frame is truncated with the line high.

## Timing
- Latency from `fifo_empty` falling (seen in IDLE at cycle n):
  - `fifo_rd` high in n+1.
  - Capture at the end of n+2.
  - `tx`=0 starting at n+3.
- Frame: `(DATA_W+2)·CLKS_PER_BIT` cycles on the line. Add one `CLKS_PER_BIT` with parity.
- Back-to-back bytes: per-byte period = frame + 3 cycles (IDLE, FETCH, LOAD). `tx` holds 1 during those 3 gap cycles.
- `tx_done` coincides with the last CLK of STOP. IDLE follows on the next edge.
- `busy` rises in the FETCH cycle and falls on entry to IDLE.

## Configuration
- `SFIFO_UART_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. It drives the even-parity bit, XOR of the captured byte, for `CLKS_PER_BIT` cycles.
- Undefined: no PARITY state, plain 8N1, and the parity logic is absent.

## Structure
- Package `sfifo_uart_pkg`:
  - State encoding: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
  - Line-level constants: `LINE_IDLE`=1, `START_BIT`=0, `STOP_BIT`=1.
- One sub-module, `uart_baud_gen`:
  - Parameterized by `CLKS_PER_BIT`.
  - Inputs `CLK`, `RST`, `clr`; output `bit_tick`, high in the last cycle of each bit period.
  - The FSM pulses `clr` on entry to START.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: FIFO holds 0xA5.
  - `fifo_rd` pulses once.
  - `tx` = 1,1,1 gap, then 0 ×4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 ×4.
  - `tx_done` pulses once; `busy` is low afterwards.
- FIFO empty for 100 cycles: `fifo_rd`=0, `tx`=1, `busy`=0 throughout.
- Back-to-back 0x00 then 0xFF:
  - Exactly two `fifo_rd` pulses, 43 cycles apart (`CLKS_PER_BIT`=4).
  - Both frames decode correctly.
  - No extra read occurs after `fifo_empty` rises.
- Assert `RST` mid-DATA of 0x3C:
  - `tx`=1, `busy`=0, `fifo_rd`=0 immediately, without waiting for a clock.
  - After release, the next FIFO byte is sent as a full frame.
- `fifo_empty` toggles during START/DATA/STOP: no `fifo_rd` until IDLE.
- With `SFIFO_UART_TX_PARITY_EN`:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Frame length is 11·`CLKS_PER_BIT` cycles.

Source files
------------

// File: rtl/sfifo_uart_pkg.sv
// Shared FSM encoding and serial line levels for the FIFO-draining UART transmitter.
package sfifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last CLK of every CLKS_PER_BIT window.
// clr restarts the window so the first bit of a frame gets a full period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/sfifo_uart_tx.sv
// Pops one FIFO byte per frame and sends it as 8N1; SFIFO_UART_TX_PARITY_EN adds an even-parity bit.
// tx falls 3 cycles after IDLE sees fifo_empty low; back-to-back frames are separated by 3 idle-high cycles.
module sfifo_uart_tx
  import sfifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              bit_tick;
  logic              clr;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (clr),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // fifo_data is only valid in LOAD, the cycle after the FETCH read strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (state == LOAD) begin
      shreg   <= fifo_data;
      bit_idx <= '0;
    end else if (state == DATA && bit_tick) begin
      shreg   <= shreg >> 1;
      bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
    end
  end

`ifdef SFIFO_UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_q <= 1'b0;
    end else if (state == LOAD) begin
      par_q <= ^fifo_data;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    clr       = 1'b0;
    tx_done   = 1'b0;
    tx        = LINE_IDLE;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = FETCH;
      FETCH: begin
        fifo_rd   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        clr       = 1'b1;
        state_nxt = START;
      end
      START: begin
        tx = START_BIT;
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_tick && bit_idx == LAST_IDX) begin
`ifdef SFIFO_UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef SFIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx = par_q;
        if (bit_tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        tx = STOP_BIT;
        if (bit_tick) begin
          tx_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sfifo_uart_tx.sv
// Directed bench for sfifo_uart_tx with a registered-read FIFO model and a frame-decoding scoreboard.
module tb_sfifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef SFIFO_UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB    = DW + 2 + int'(PAR);
  localparam int FRAME = NB * CPB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd, tx, busy, tx_done;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         mask = 1'b0;
  bit         toggle = 1'b0;
  int         cyc = 0;
  int         rd_count = 0;
  int         rd_last = 0;
  int         rd_prev = 0;
  bit         in_frame = 1'b0;
  int         fcnt = 0;
  logic [7:0] acc = '0;

  sfifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mq.push_back(b);
    exp_q.push_back(b);
    fifo_empty = mask || (mq.size() == 0);
  endtask

  // One clock: FIFO model answers last cycle's read, then the line decoder advances.
  task automatic step();
    logic rd_pre;
    logic [7:0] e;
    rd_pre = fifo_rd;
    @(posedge CLK);
    #1;
    cyc++;
    if (rd_pre && mq.size() > 0) fifo_data = mq.pop_front();
    mask       = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
    fifo_empty = mask || (mq.size() == 0);
    if (fifo_rd === 1'b1) begin
      rd_count++;
      rd_prev = rd_last;
      rd_last = cyc;
    end
    if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        fcnt     = 0;
        acc      = '0;
      end
    end else begin
      fcnt++;
      if (fcnt < CPB * (DW + 1) && (fcnt % CPB) == CPB / 2) acc = {tx, acc[7:1]};
      if (PAR && fcnt == CPB * (DW + 1) + CPB / 2) chk("sb_parity", tx, ^acc);
      if (fcnt == FRAME - CPB + CPB / 2) begin
        in_frame = 1'b0;
        chk("sb_stop", tx, 1);
        chk("sb_has_exp", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_byte", acc, e);
        end
      end
    end
  endtask

  // Cycle-exact frame check; off 0 is the FETCH cycle, off FRAME+2 the following IDLE.
  task automatic run_frame(input logic [7:0] b, input bit tog);
    logic e_tx;
    int   bitn;
    for (int off = 0; off <= FRAME + 2; off++) begin
      toggle = tog && off >= 1 && off < FRAME;
      step();
      if (off < 2 || off >= FRAME + 2) begin
        e_tx = 1'b1;
      end else begin
        bitn = (off - 2) / CPB;
        if (bitn == 0)                   e_tx = 1'b0;
        else if (bitn <= DW)             e_tx = b[bitn-1];
        else if (PAR && bitn == DW + 1)  e_tx = ^b;
        else                             e_tx = 1'b1;
      end
      chk($sformatf("tx@%0d", off), tx, e_tx);
      chk($sformatf("rd@%0d", off), fifo_rd, off == 0);
      chk($sformatf("busy@%0d", off), busy, off <= FRAME + 1);
      chk($sformatf("done@%0d", off), tx_done, off == FRAME + 1);
    end
    toggle = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_done", tx_done, 0);
    #3 RST = 1'b0;
    step();
    step();

    // single byte
    push(8'hA5);
    run_frame(8'hA5, 1'b0);
    chk("single_rd_count", rd_count, 1);

    // empty FIFO stays quiet
    for (int i = 0; i < 100; i++) begin
      step();
      chk("empty_rd", fifo_rd, 0);
      chk("empty_tx", tx, 1);
      chk("empty_busy", busy, 0);
    end

    // back-to-back
    rd_count = 0;
    push(8'h00);
    push(8'hFF);
    run_frame(8'h00, 1'b0);
    run_frame(8'hFF, 1'b0);
    repeat (10) step();
    chk("b2b_rd_count", rd_count, 2);
    chk("b2b_rd_spacing", rd_last - rd_prev, FRAME + 3);

    // asynchronous reset in the middle of DATA
    push(8'h3C);
    for (int i = 0; i < 2 + 4 * CPB; i++) step();
    chk("pre_rst_busy", busy, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rd", fifo_rd, 0);
    chk("arst_done", tx_done, 0);
    exp_q.delete();
    in_frame = 1'b0;
    @(posedge CLK);
    #3;
    chk("rst_hold_tx", tx, 1);
    RST = 1'b0;
    push(8'h96);
    run_frame(8'h96, 1'b0);

    // fifo_empty wiggles mid-frame must not cause a read
    rd_count = 0;
    push(8'h5A);
    push(8'hC3);
    run_frame(8'h5A, 1'b1);
    run_frame(8'hC3, 1'b0);
    repeat (5) step();
    chk("tog_rd_count", rd_count, 2);

`ifdef SFIFO_UART_TX_PARITY_EN
    push(8'h07);
    run_frame(8'h07, 1'b0);
    push(8'h03);
    run_frame(8'h03, 1'b0);
`endif

    repeat (5) step();
    chk("sb_drained", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
